// File: rtl/enigma_pkg.sv
// Shared types and constants for the enigma_param rotor cipher.
package enigma_pkg;

    localparam int DEF_CODE_W     = 6;
    localparam int DEF_NUM_ROTORS = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/enigma_rotor.sv
// One rotor: forward/inverse tables, odometer offset and both lookups.
module enigma_rotor #(
    parameter int CODE_W = 6
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic [CODE_W-1:0] wr_addr,
    input  logic [CODE_W-1:0] wr_data,
    input  logic              step_in,
    output logic              carry_out,
    input  logic [CODE_W-1:0] fwd_in,
    output logic [CODE_W-1:0] fwd_out,
    input  logic [CODE_W-1:0] inv_in,
    output logic [CODE_W-1:0] inv_out
);
    localparam int D = 1 << CODE_W;

    logic [CODE_W-1:0] r_tbl   [D];
    logic [CODE_W-1:0] inv_tbl [D];
    logic [CODE_W-1:0] off;
    logic [CODE_W-1:0] fwd_addr;

    // Tables are deliberately not reset so they survive srst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tbl[wr_addr]   <= wr_data;
            inv_tbl[wr_data] <= wr_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            off <= '0;
        end else if (step_in) begin
            off <= off + CODE_W'(1);
        end
    end

    assign carry_out = step_in && (off == '1);
    assign fwd_addr  = fwd_in + off;
    assign fwd_out   = r_tbl[fwd_addr];
    assign inv_out   = inv_tbl[inv_in] - off;

endmodule

// File: rtl/enigma_param.sv
// Cascaded rotor cipher: table load phase, then 1-cycle encrypt/decrypt stream.
//   state    | meaning
//   ST_IDLE  | after reset, waiting for first table write
//   ST_LOAD  | table writes in progress
//   ST_READY | tables frozen, symbols accepted until srst
module enigma_param
    import enigma_pkg::*;
#(
    parameter int  CODE_W     = DEF_CODE_W,
    parameter int  NUM_ROTORS = DEF_NUM_ROTORS,
    localparam int TBL_W      = (clog2(NUM_ROTORS) > 1) ? clog2(NUM_ROTORS) : 1,
    localparam int IDX_W      = TBL_W + CODE_W
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load,
    input  logic              encrypt,
    input  logic              crypt_mode,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [CODE_W-1:0] code_in,
    output logic [CODE_W-1:0] code_out,
    output logic              code_valid
);
    state_t state, state_nx;

    logic              load_ok;
    logic              accept;
    logic [TBL_W-1:0]  tbl_sel;
    logic [CODE_W-1:0] ent_sel;

    logic [CODE_W-1:0] fwd_y [NUM_ROTORS+1];
    logic [CODE_W-1:0] inv_z [NUM_ROTORS+1];
    logic              carry [NUM_ROTORS+1];

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (load)  state_nx = ST_LOAD;
            ST_LOAD:  if (!load) state_nx = ST_READY;
            ST_READY: state_nx = ST_READY;
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign load_ok = load && !srst && (state == ST_IDLE || state == ST_LOAD);
    assign accept  = encrypt && !srst && (state == ST_READY);
    assign tbl_sel = load_idx[IDX_W-1:CODE_W];
    assign ent_sel = load_idx[CODE_W-1:0];

    // Forward path runs rotor 0 first; inverse path enters at the last rotor.
    assign fwd_y[0]          = code_in;
    assign inv_z[NUM_ROTORS] = code_in;
    assign carry[0]          = accept;

    for (genvar i = 0; i < NUM_ROTORS; i++) begin : g_rotor
        enigma_rotor #(.CODE_W(CODE_W)) u_rotor (
            .clk       (clk),
            .srst      (srst),
            .wr_en     (load_ok && (tbl_sel == TBL_W'(i))),
            .wr_addr   (ent_sel),
            .wr_data   (code_in),
            .step_in   (carry[i]),
            .carry_out (carry[i+1]),
            .fwd_in    (fwd_y[i]),
            .fwd_out   (fwd_y[i+1]),
            .inv_in    (inv_z[i+1]),
            .inv_out   (inv_z[i])
        );
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            code_out   <= '0;
            code_valid <= 1'b0;
        end else begin
            code_valid <= accept;
            if (accept) begin
                code_out <= crypt_mode ? inv_z[0] : fwd_y[NUM_ROTORS];
            end
        end
    end

endmodule

// File: tb/tb_enigma_param.sv
// Randomized bench for enigma_param against a step-count reference model.
module tb_enigma_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       srst, load, encrypt, crypt_mode;
    logic [7:0] load_idx;
    logic [5:0] code_in, code_out;
    logic       code_valid;

    logic       s_srst, s_load, s_encrypt, s_crypt_mode;
    logic [4:0] s_load_idx;
    logic [3:0] s_code_in, s_code_out;
    logic       s_code_valid;

    enigma_param dut (
        .clk(clk), .srst(srst), .load(load), .encrypt(encrypt),
        .crypt_mode(crypt_mode), .load_idx(load_idx), .code_in(code_in),
        .code_out(code_out), .code_valid(code_valid)
    );

    enigma_param #(.CODE_W(4), .NUM_ROTORS(1)) dut_s (
        .clk(clk), .srst(s_srst), .load(s_load), .encrypt(s_encrypt),
        .crypt_mode(s_crypt_mode), .load_idx(s_load_idx), .code_in(s_code_in),
        .code_out(s_code_out), .code_valid(s_code_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int r_m [3][64];
    int cnt;
    int pt [200];
    int ct [200];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offsets derived from the total number of accepted symbols.
    function automatic int off_of(input int i);
        return (cnt >> (6 * i)) & 63;
    endfunction

    function automatic int enc_model(input int x);
        int y = x;
        for (int i = 0; i < 3; i++) y = r_m[i][(y + off_of(i)) & 63];
        return y;
    endfunction

    function automatic int dec_model(input int x);
        int z = x;
        int k;
        for (int i = 2; i >= 0; i--) begin
            k = 0;
            for (int j = 0; j < 64; j++) if (r_m[i][j] == z) k = j;
            z = (k - off_of(i)) & 63;
        end
        return z;
    endfunction

    task automatic send(input bit mode, input int sym, input string tag, output int res);
        res        = mode ? dec_model(sym) : enc_model(sym);
        encrypt    = 1'b1;
        crypt_mode = mode;
        code_in    = 6'(sym);
        tick();
        check_eq({tag, "_valid"}, 32'(code_valid), 1);
        check_eq(tag, 32'(code_out), res);
        cnt++;
    endtask

    task automatic do_reset();
        srst = 1'b1; load = 1'b0; encrypt = 1'b0;
        tick();
        srst = 1'b0;
        cnt  = 0;
    endtask

    task automatic load_all();
        load = 1'b1;
        for (int t = 0; t < 3; t++) begin
            for (int e = 0; e < 64; e++) begin
                load_idx = 8'(t * 64 + e);
                code_in  = 6'(r_m[t][e]);
                tick();
            end
        end
        load = 1'b0;
        tick();
    endtask

    task automatic enter_ready_no_write();
        load = 1'b1; load_idx = 8'(3 << 6); code_in = 6'd17;
        tick();
        load = 1'b0;
        tick();
    endtask

    initial begin
        int res, tmp, j, held;
        srst = 1'b1; load = 1'b0; encrypt = 1'b0; crypt_mode = 1'b0;
        load_idx = '0; code_in = '0;
        s_srst = 1'b1; s_load = 1'b0; s_encrypt = 1'b0; s_crypt_mode = 1'b0;
        s_load_idx = '0; s_code_in = '0;
        tick();
        tick();
        check_eq("rst_valid", 32'(code_valid), 0);
        check_eq("rst_out", 32'(code_out), 0);
        srst = 1'b0; s_srst = 1'b0;
        cnt = 0;

        // Single-rotor 4-bit instance: identity table, 17 zeros.
        s_load = 1'b1;
        for (int e = 0; e < 16; e++) begin
            s_load_idx = 5'(e); s_code_in = 4'(e);
            tick();
        end
        s_load = 1'b0;
        tick();
        s_encrypt = 1'b1; s_code_in = 4'd0;
        for (int k = 0; k < 17; k++) begin
            tick();
            check_eq("small_valid", 32'(s_code_valid), 1);
            check_eq("small_out", 32'(s_code_out), k % 16);
        end
        s_encrypt = 1'b0;

        // Identity tables, odometer carry into rotor 1.
        for (int t = 0; t < 3; t++) for (int e = 0; e < 64; e++) r_m[t][e] = e;
        do_reset();
        load_all();
        check_eq("ready_idle_valid", 32'(code_valid), 0);
        for (int k = 0; k < 65; k++) begin
            tmp = (k < 2) ? 5 : (k == 64 ? 0 : int'($urandom_range(63)));
            send(1'b0, tmp, "ident", res);
            if (k == 0) check_eq("ident_first", 32'(code_out), 5);
            if (k == 1) check_eq("ident_second", 32'(code_out), 6);
            if (k == 64) check_eq("ident_wrap64", 32'(code_out), 1);
        end
        held = enc_model(0);
        encrypt = 1'b0;
        tick();
        check_eq("bubble_valid", 32'(code_valid), 0);
        check_eq("bubble_hold", 32'(code_out), 1);
        send(1'b0, 9, "after_bubble", res);
        encrypt = 1'b0;

        // Writes to a nonexistent rotor and encrypt during LOAD are ignored.
        do_reset();
        load = 1'b1; encrypt = 1'b1;
        for (int e = 0; e < 8; e++) begin
            load_idx = 8'((3 << 6) + e);
            code_in  = 6'($urandom_range(63));
            tick();
            check_eq("load_enc_valid", 32'(code_valid), 0);
        end
        load = 1'b0;
        tick();
        check_eq("load_exit_valid", 32'(code_valid), 0);
        for (int k = 0; k < 8; k++) send(1'b0, k * 7 + 1, "bad_rotor", res);
        encrypt = 1'b0;

        // Rotor 0 = increment, others identity retained from before.
        for (int e = 0; e < 64; e++) r_m[0][e] = (e + 1) % 64;
        do_reset();
        load = 1'b1;
        for (int e = 0; e < 64; e++) begin
            load_idx = 8'(e); code_in = 6'(r_m[0][e]);
            tick();
        end
        load = 1'b0;
        tick();
        send(1'b0, 63, "inc_wrap", res);
        check_eq("inc_wrap_const", 32'(code_out), 0);
        encrypt = 1'b0;
        tick();
        check_eq("inc_one_cycle", 32'(code_valid), 0);

        // Random permutations: encrypt 200, then decrypt back.
        for (int t = 0; t < 3; t++) begin
            for (int e = 0; e < 64; e++) r_m[t][e] = e;
            for (int e = 63; e > 0; e--) begin
                j = int'($urandom_range(e));
                tmp = r_m[t][e]; r_m[t][e] = r_m[t][j]; r_m[t][j] = tmp;
            end
        end
        do_reset();
        load_all();
        for (int k = 0; k < 200; k++) begin
            pt[k] = int'($urandom_range(63));
            send(1'b0, pt[k], "rand_enc", res);
            ct[k] = res;
        end
        do_reset();
        load_all();
        for (int k = 0; k < 200; k++) begin
            send(1'b1, ct[k], "rand_dec", res);
            check_eq("rand_roundtrip", 32'(code_out), pt[k]);
        end
        encrypt = 1'b0;

        // Mid-stream reset, re-entry without reload; load in READY ignored.
        do_reset();
        enter_ready_no_write();
        for (int k = 0; k < 10; k++) begin
            if (k >= 8) begin
                load = 1'b1; load_idx = 8'(k); code_in = 6'(k + 20);
            end
            send(1'b0, int'($urandom_range(63)), "pre_srst", res);
        end
        load = 1'b0;
        srst = 1'b1;
        tick();
        check_eq("srst_valid", 32'(code_valid), 0);
        check_eq("srst_out", 32'(code_out), 0);
        srst = 1'b0; encrypt = 1'b0; cnt = 0;
        tick();
        check_eq("post_srst_valid", 32'(code_valid), 0);
        enter_ready_no_write();
        for (int k = 0; k < 6; k++) send(1'b0, int'($urandom_range(63)), "reentry", res);
        send(1'b1, 33, "reentry_dec", res);
        encrypt = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/enigma_param.md
ENIGMA_PARAM -- requirements
Module: enigma_param

Interface
REQ-001 SHALL have parameter CODE_W, default 6: symbol width; table depth D = 2^CODE_W.
REQ-002 SHALL have parameter NUM_ROTORS, default 3, legal range 1..4: number of cascaded rotor tables.
REQ-003 SHALL have derived localparam TBL_W = max(1, clog2(NUM_ROTORS)), giving load_idx width IDX_W = TBL_W + CODE_W.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 srst  input  1  synchronous reset, active-high.
REQ-006 load  input  1  table-load enable, level-sensitive; honoured only in IDLE and LOAD.
REQ-007 encrypt  input  1  symbol-valid, level-sensitive; honoured only in READY.
REQ-008 crypt_mode  input  1  0 = encrypt, 1 = decrypt; sampled on every accepted symbol.
REQ-009 load_idx  input  IDX_W  upper TBL_W bits select the rotor, lower CODE_W bits select the entry.
REQ-010 code_in  input  CODE_W  table data while loading, plaintext/ciphertext symbol while crypting.
REQ-011 code_out  output  CODE_W  result symbol, registered.
REQ-012 code_valid  output  1  code_out qualifier, registered.

Function
REQ-013 FSM states SHALL be IDLE, LOAD and READY; IDLE->LOAD on load=1; LOAD->LOAD while load=1; LOAD->READY on load=0; READY is terminal until srst.
REQ-014 A cycle with load=1 in IDLE or LOAD SHALL write R_t[e] <= code_in and INV_t[code_in] <= e, where t = load_idx[IDX_W-1:CODE_W] and e = load_idx[CODE_W-1:0].
REQ-015 A write with t >= NUM_ROTORS SHALL be ignored; the FSM transition still occurs.
REQ-016 load=1 in READY SHALL be ignored; encrypt=1 in IDLE/LOAD SHALL be ignored, with no output and no stepping.
REQ-017 Each rotor i SHALL hold an offset off_i of CODE_W bits; all arithmetic is mod D (natural CODE_W-bit wrap).
REQ-018 Encrypt: y0 = code_in; y_{i+1} = R_i[y_i + off_i] for i = 0..N-1; result = y_N.
REQ-019 Decrypt: z_N = code_in; z_i = INV_i[z_{i+1}] - off_i for i = N-1..0; result = z_0.
REQ-020 Each READY cycle with encrypt=1 SHALL use the current offsets for the computation and then step them.
REQ-021 Stepping SHALL work as an odometer: off_0 += 1; off_i += 1 only when off_{i-1} wraps D-1 -> 0; a wrap of off_{N-1} carries nowhere.
REQ-022 Latency SHALL be 1: result in code_out and code_valid=1 in the cycle after the accepted symbol.
REQ-023 encrypt=0 in READY SHALL give code_valid=0 on the next cycle, hold code_out, and leave the offsets unchanged.
REQ-024 Back-to-back symbols SHALL be accepted every cycle with no bubbles.
REQ-025 Tables SHALL be assumed to be permutations; behaviour with non-bijective tables is undefined in decrypt mode only.

Reset
REQ-026 On srst=1 at a clock edge: state = IDLE, all off_i = 0, code_out = 0, code_valid = 0; srst wins over load and encrypt.
REQ-027 Table contents (R_i, INV_i) SHALL NOT be reset; they persist across srst until rewritten.
REQ-028 srst in the middle of a stream SHALL abort it with no further code_valid; the in-flight output is dropped.

Structure
REQ-029 Package enigma_pkg SHALL hold the FSM state enum, the clog2 function and the default CODE_W/NUM_ROTORS constants.
REQ-030 Sub-module enigma_rotor (parameter CODE_W) SHALL hold one R table, one INV table, the offset register with its carry-out, and the forward and inverse lookups; the top instantiates NUM_ROTORS copies.

Verification
REQ-031 N=3, CODE_W=6, all tables identity, encrypt: first symbol 5 -> 5; second symbol 5 -> 6; symbol #64 (0-based) with code_in 0 -> 1 (off_0 wrapped, off_1=1).
REQ-032 R_0[k] = k+1 mod 64, others identity, encrypt first symbol 63 -> 0 (wrap), valid exactly 1 cycle after acceptance.
REQ-033 Random permutations, encrypt 200 random symbols; srst, reload, decrypt the ciphertext -> original 200 symbols, in order, no gaps.
REQ-034 Load writes with load_idx = 3<<6 when N=3 -> all tables unchanged; encrypt=1 during LOAD -> code_valid stays 0, offsets stay 0.
REQ-035 Assert srst after 10 symbols mid-stream -> next cycle code_valid=0 and code_out=0; re-enter READY without reload -> first symbol uses offsets 0 and the old tables.
REQ-036 N=1, CODE_W=4, identity table: 17 consecutive symbols of 0 -> outputs 0,1,...,15,0.
